// File: rtl/alu_ex_stage.sv
// alu_ex_stage: execute-stage wrapper in front of a 32-bit ALU.
//
// Takes decoded operations over a valid/ready handshake into a one-entry
// operand register that drives the ALU. On the following edge it captures the
// ALU result and flags into an in-order output buffer for writeback. Signed
// overflow on ADD/SUB can optionally raise a trap that holds off new requests
// until it is acknowledged.
//
// Build option:
//   ALU_EX_SKID_EN  defined   -> output buffer depth 2 (absorbs a one-cycle
//                                consumer stall at full rate)
//                   undefined -> output buffer depth 1
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   in_valid/in_ready             request handshake
//   in_A, in_B, in_ALUop, in_tag  operands, op code, destination tag
//   in_trap_ov                    trap on signed ADD/SUB overflow
//   alu_A, alu_B, alu_ALUop       drive the ALU (from the operand register)
//   alu_Result, alu_Overflow,
//   alu_CarryOut, alu_Zero        ALU response
//   out_valid/out_ready           output buffer head handshake
//   out_result, out_zero,
//   out_carry, out_overflow,
//   out_tag                       output buffer head contents
//   exc_valid, exc_tag            pending overflow trap and its tag
//   exc_clear                     trap acknowledge
module alu_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_A,
  input  logic [DATA_WIDTH-1:0] in_B,
  input  logic [2:0]            in_ALUop,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  input  logic                  in_trap_ov,
  output logic [DATA_WIDTH-1:0] alu_A,
  output logic [DATA_WIDTH-1:0] alu_B,
  output logic [2:0]            alu_ALUop,
  input  logic [DATA_WIDTH-1:0] alu_Result,
  input  logic                  alu_Overflow,
  input  logic                  alu_CarryOut,
  input  logic                  alu_Zero,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_zero,
  output logic                  out_carry,
  output logic                  out_overflow,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  exc_valid,
  output logic [TAG_WIDTH-1:0]  exc_tag,
  input  logic                  exc_clear
);

`ifdef ALU_EX_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {RUN, TRAP} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic                  zero;
    logic                  carry;
    logic                  ovf;
    logic [TAG_WIDTH-1:0]  tag;
  } ob_entry_t;

  function automatic logic op_supported(input logic [2:0] op);
    case (op)
      3'b000, 3'b001, 3'b010, 3'b110, 3'b111: op_supported = 1'b1;
      default:                                op_supported = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_addsub(input logic [2:0] op);
    op_is_addsub = (op == 3'b010) || (op == 3'b110);
  endfunction

  // Operand register (stage p0)
  logic [DATA_WIDTH-1:0] a_p0, b_p0;
  logic [2:0]            op_p0;     // already remapped: unsupported ops become 000
  logic                  unsup_p0;
  logic [TAG_WIDTH-1:0]  tag_p0;
  logic                  trap_p0;
  logic                  vld_p0;

  // Output buffer (stage p1); entry 0 is always the head
  ob_entry_t             ob_p1 [DEPTH];
  ob_entry_t             ob_nxt [DEPTH];
  logic [CW-1:0]         cnt_p1;

  state_t                state;
  logic                  exc_valid_r;
  logic [TAG_WIDTH-1:0]  exc_tag_r;

  logic                  pop, adv, trap_hit, push, accept;
  logic [CW-1:0]         wr_pos;
  logic [IW-1:0]         wr_idx;
  ob_entry_t             new_entry;

  assign pop      = (cnt_p1 != '0) && out_ready;
  assign adv      = vld_p0 && ((cnt_p1 < CW'(DEPTH)) || pop);
  assign trap_hit = adv && (state == RUN) && trap_p0 && alu_Overflow && op_is_addsub(op_p0);
  // A trapping op is consumed from the operand register but never reaches writeback.
  assign push     = adv && !trap_hit;
  assign in_ready = rst_n && (state == RUN) && (!vld_p0 || adv);
  assign accept   = in_valid && in_ready;

  always_comb begin
    new_entry = '{result: alu_Result, zero: alu_Zero, carry: alu_CarryOut,
                  ovf: alu_Overflow, tag: tag_p0};
    if (unsup_p0) begin
      new_entry = '{result: '0, zero: 1'b1, carry: 1'b0, ovf: 1'b0, tag: tag_p0};
    end
  end

  // Shift on pop, then write behind the surviving entries so order is kept.
  always_comb begin
    ob_nxt = ob_p1;
    wr_pos = cnt_p1 - CW'(pop);
    wr_idx = wr_pos[IW-1:0];
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        ob_nxt[i] = ob_p1[i+1];
      end
    end
    if (push) begin
      ob_nxt[wr_idx] = new_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_p0        <= '0;
      b_p0        <= '0;
      op_p0       <= '0;
      unsup_p0    <= 1'b0;
      tag_p0      <= '0;
      trap_p0     <= 1'b0;
      vld_p0      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ob_p1[i]  <= '0;
      end
      cnt_p1      <= '0;
      state       <= RUN;
      exc_valid_r <= 1'b0;
      exc_tag_r   <= '0;
    end else begin
      if (accept) begin
        a_p0     <= in_A;
        b_p0     <= in_B;
        op_p0    <= op_supported(in_ALUop) ? in_ALUop : 3'b000;
        unsup_p0 <= !op_supported(in_ALUop);
        tag_p0   <= in_tag;
        trap_p0  <= in_trap_ov;
        vld_p0   <= 1'b1;
      end else if (adv) begin
        vld_p0   <= 1'b0;
      end

      ob_p1  <= ob_nxt;
      cnt_p1 <= cnt_p1 + CW'(push) - CW'(pop);

      case (state)
        RUN: begin
          if (trap_hit) begin
            state       <= TRAP;
            exc_valid_r <= 1'b1;
            exc_tag_r   <= tag_p0;
          end
        end
        TRAP: begin
          if (exc_clear) begin
            state       <= RUN;
            exc_valid_r <= 1'b0;
          end
        end
        default: begin
          state       <= RUN;
          exc_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign alu_A        = a_p0;
  assign alu_B        = b_p0;
  assign alu_ALUop    = op_p0;

  assign out_valid    = (cnt_p1 != '0);
  assign out_result   = ob_p1[0].result;
  assign out_zero     = ob_p1[0].zero;
  assign out_carry    = ob_p1[0].carry;
  assign out_overflow = ob_p1[0].ovf;
  assign out_tag      = ob_p1[0].tag;

  assign exc_valid    = exc_valid_r;
  assign exc_tag      = exc_tag_r;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed testbench for alu_ex_stage. The bench also plays the role of the
// downstream 32-bit ALU with a small behavioural model.
module tb_alu_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_A, in_B;
  logic [2:0]  in_ALUop;
  logic [4:0]  in_tag;
  logic        in_trap_ov;
  logic [31:0] alu_A, alu_B;
  logic [2:0]  alu_ALUop;
  logic [31:0] alu_Result;
  logic        alu_Overflow, alu_CarryOut, alu_Zero;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_zero, out_carry, out_overflow;
  logic [4:0]  out_tag;
  logic        exc_valid;
  logic [4:0]  exc_tag;
  logic        exc_clear;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_A), .in_B(in_B), .in_ALUop(in_ALUop), .in_tag(in_tag),
    .in_trap_ov(in_trap_ov),
    .alu_A(alu_A), .alu_B(alu_B), .alu_ALUop(alu_ALUop),
    .alu_Result(alu_Result), .alu_Overflow(alu_Overflow),
    .alu_CarryOut(alu_CarryOut), .alu_Zero(alu_Zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_carry(out_carry),
    .out_overflow(out_overflow), .out_tag(out_tag),
    .exc_valid(exc_valid), .exc_tag(exc_tag), .exc_clear(exc_clear)
  );

  // Behavioural ALU
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum      = '0;
    alu_Result   = '0;
    alu_CarryOut = 1'b0;
    alu_Overflow = 1'b0;
    case (alu_ALUop)
      3'b000: alu_Result = alu_A & alu_B;
      3'b001: alu_Result = alu_A | alu_B;
      3'b010: begin
        alu_sum      = {1'b0, alu_A} + {1'b0, alu_B};
        alu_Result   = alu_sum[31:0];
        alu_CarryOut = alu_sum[32];
        alu_Overflow = (alu_A[31] == alu_B[31]) && (alu_sum[31] != alu_A[31]);
      end
      3'b110: begin
        alu_sum      = {1'b0, alu_A} + {1'b0, ~alu_B} + 33'd1;
        alu_Result   = alu_sum[31:0];
        alu_CarryOut = alu_sum[32];
        alu_Overflow = (alu_A[31] != alu_B[31]) && (alu_sum[31] != alu_A[31]);
      end
      3'b111: alu_Result = ($signed(alu_A) < $signed(alu_B)) ? 32'd1 : 32'd0;
      default: alu_Result = '0;
    endcase
    alu_Zero = (alu_Result == 32'd0);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [4:0] tag, input logic trap);
    in_valid = 1'b1; in_A = a; in_B = b; in_ALUop = op; in_tag = tag; in_trap_ov = trap;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; out_ready = 1'b0; exc_clear = 1'b0;
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010, 5'd31, 1'b1);
    repeat (3) tick;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (exc_valid !== 1'b0) begin n_bad++; $display("FAIL rst_exc_valid got %b want 0", exc_valid); end
    n_cmp++; if (alu_A !== 32'd0) begin n_bad++; $display("FAIL rst_alu_A got %h want 0", alu_A); end
    n_cmp++; if (out_result !== 32'd0) begin n_bad++; $display("FAIL rst_out_result got %h want 0", out_result); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rel_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add;
    out_ready = 1'b0;
    drive(32'h7FFF_FFFF, 32'd1, 3'b010, 5'd5, 1'b0);
    tick;
    in_valid = 1'b0;
    n_cmp++; if (alu_A !== 32'h7FFF_FFFF) begin n_bad++; $display("FAIL add_alu_A got %h want 7fffffff", alu_A); end
    n_cmp++; if (alu_ALUop !== 3'b010) begin n_bad++; $display("FAIL add_alu_op got %b want 010", alu_ALUop); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL add_early_valid got %b want 0", out_valid); end
    tick;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid got %b want 1", out_valid); end
    n_cmp++; if (out_result !== 32'h8000_0000) begin n_bad++; $display("FAIL add_result got %h want 80000000", out_result); end
    n_cmp++; if (out_overflow !== 1'b1) begin n_bad++; $display("FAIL add_ovf got %b want 1", out_overflow); end
    n_cmp++; if (out_carry !== 1'b0) begin n_bad++; $display("FAIL add_carry got %b want 0", out_carry); end
    n_cmp++; if (out_tag !== 5'd5) begin n_bad++; $display("FAIL add_tag got %0d want 5", out_tag); end
    tick;
    n_cmp++; if (out_result !== 32'h8000_0000) begin n_bad++; $display("FAIL add_hold got %h want 80000000", out_result); end
    out_ready = 1'b1;
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL add_pop got %b want 0", out_valid); end
  endtask

  task automatic test_trap;
    out_ready = 1'b1;
    drive(32'h8000_0000, 32'd1, 3'b110, 5'd9, 1'b1);
    tick;
    in_valid = 1'b0;
    tick;
    n_cmp++; if (exc_valid !== 1'b1) begin n_bad++; $display("FAIL trap_exc_valid got %b want 1", exc_valid); end
    n_cmp++; if (exc_tag !== 5'd9) begin n_bad++; $display("FAIL trap_exc_tag got %0d want 9", exc_tag); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL trap_no_ob got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL trap_in_ready got %b want 0", in_ready); end
    tick;
    n_cmp++; if (exc_valid !== 1'b1) begin n_bad++; $display("FAIL trap_hold got %b want 1", exc_valid); end
    exc_clear = 1'b1;
    tick;
    exc_clear = 1'b0;
    n_cmp++; if (exc_valid !== 1'b0) begin n_bad++; $display("FAIL clr_exc_valid got %b want 0", exc_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL clr_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_backpressure;
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [2:0]  vop [4];
    logic [31:0] vres [4];
    logic        vz [4];
    logic        exp_rdy;
    int sent, got;
    va = '{32'd5, 32'd7, 32'h0000_F0F0, 32'd0};
    vb = '{32'd7, 32'd5, 32'h0000_FF00, 32'd0};
    vop = '{3'b111, 3'b111, 3'b000, 3'b001};
    vres = '{32'd1, 32'd0, 32'h0000_F000, 32'd0};
    vz = '{1'b0, 1'b1, 1'b0, 1'b1};
`ifdef ALU_EX_SKID_EN
    exp_rdy = 1'b1;
`else
    exp_rdy = 1'b0;
`endif
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      if (sent < 4) drive(va[sent], vb[sent], vop[sent], 5'(sent + 1), 1'b0);
      else in_valid = 1'b0;
      out_ready = !(cyc >= 2 && cyc <= 4);
      #1;
      if (cyc == 2) begin
        n_cmp++; if (in_ready !== exp_rdy) begin n_bad++; $display("FAIL bp_stall_ready got %b want %b", in_ready, exp_rdy); end
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        n_cmp++; if (out_result !== vres[got]) begin n_bad++; $display("FAIL bp_result[%0d] got %h want %h", got, out_result, vres[got]); end
        n_cmp++; if (out_zero !== vz[got]) begin n_bad++; $display("FAIL bp_zero[%0d] got %b want %b", got, out_zero, vz[got]); end
        n_cmp++; if (out_tag !== 5'(got + 1)) begin n_bad++; $display("FAIL bp_tag[%0d] got %0d want %0d", got, out_tag, got + 1); end
        got++;
      end
      tick;
    end
    in_valid = 1'b0;
    n_cmp++; if (got != 4) begin n_bad++; $display("FAIL bp_count got %0d want 4", got); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained got %b want 0", out_valid); end
  endtask

  task automatic test_unsupported;
    out_ready = 1'b0;
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b100, 5'd7, 1'b1);
    tick;
    in_valid = 1'b0;
    n_cmp++; if (alu_ALUop !== 3'b000) begin n_bad++; $display("FAIL unsup_alu_op got %b want 000", alu_ALUop); end
    tick;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL unsup_valid got %b want 1", out_valid); end
    n_cmp++; if (out_result !== 32'd0) begin n_bad++; $display("FAIL unsup_result got %h want 0", out_result); end
    n_cmp++; if (out_zero !== 1'b1) begin n_bad++; $display("FAIL unsup_zero got %b want 1", out_zero); end
    n_cmp++; if ({out_carry, out_overflow} !== 2'b00) begin n_bad++; $display("FAIL unsup_flags got %b want 00", {out_carry, out_overflow}); end
    n_cmp++; if (out_tag !== 5'd7) begin n_bad++; $display("FAIL unsup_tag got %0d want 7", out_tag); end
    n_cmp++; if (exc_valid !== 1'b0) begin n_bad++; $display("FAIL unsup_exc got %b want 0", exc_valid); end
    out_ready = 1'b1;
    tick;
  endtask

  task automatic test_reset_midstream;
    logic exp_ob;
    out_ready = 1'b0;
    drive(32'd1, 32'd1, 3'b010, 5'd1, 1'b0);
    tick;
    drive(32'h8000_0000, 32'd1, 3'b110, 5'd3, 1'b1);
    tick;
    drive(32'd2, 32'd2, 3'b010, 5'd2, 1'b0);
`ifdef ALU_EX_SKID_EN
    out_ready = 1'b0;
    exp_ob = 1'b1;
`else
    out_ready = 1'b1;
    exp_ob = 1'b0;
`endif
    tick;
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_cmp++; if (exc_valid !== 1'b1) begin n_bad++; $display("FAIL mid_trap got %b want 1", exc_valid); end
    n_cmp++; if (exc_tag !== 5'd3) begin n_bad++; $display("FAIL mid_exc_tag got %0d want 3", exc_tag); end
    n_cmp++; if (out_valid !== exp_ob) begin n_bad++; $display("FAIL mid_ob got %b want %b", out_valid, exp_ob); end
    rst_n = 1'b0;
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (exc_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_exc_valid got %b want 0", exc_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_in_ready got %b want 0", in_ready); end
    n_cmp++; if (alu_A !== 32'd0) begin n_bad++; $display("FAIL midrst_alu_A got %h want 0", alu_A); end
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrel_in_ready got %b want 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      tick;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrel_stale[%0d] got %b want 0", i, out_valid); end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_A = '0; in_B = '0; in_ALUop = '0;
    in_tag = '0; in_trap_ov = 1'b0; out_ready = 1'b0; exc_clear = 1'b0;
    test_reset;
    test_add;
    test_trap;
    test_backpressure;
    test_unsupported;
    test_reset_midstream;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_ex_stage.md
# alu_ex_stage

Execute-stage wrapper that sits directly upstream of the 32-bit ALU. It accepts decoded operations over a valid/ready handshake, registers the operands, and drives the ALU from that register. It captures the ALU result and flags into an in-order output buffer for writeback, and optionally traps on signed overflow of ADD/SUB.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand/result width.
- `TAG_WIDTH`, 5, destination-register tag width.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  stage can accept a request this cycle.
- `in_A`, `in_B`  in  DATA_WIDTH  operands.
- `in_ALUop`  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `in_tag`  in  TAG_WIDTH  destination tag, carried through unchanged.
- `in_trap_ov`  in  1  1 = signed overflow on ADD/SUB traps.
- `alu_A`, `alu_B`  out  DATA_WIDTH  to ALU.
- `alu_ALUop`  out  3  to ALU.
- `alu_Result`  in  DATA_WIDTH  from ALU.
- `alu_Overflow`, `alu_CarryOut`, `alu_Zero`  in  1  from ALU.
- `out_valid`  out  1  head of output buffer valid.
- `out_ready`  in  1  consumer accepts head.
- `out_result`  out  DATA_WIDTH  head result.
- `out_zero`, `out_carry`, `out_overflow`  out  1  head flags.
- `out_tag`  out  TAG_WIDTH  head tag.
- `exc_valid`  out  1  overflow trap pending.
- `exc_tag`  out  TAG_WIDTH  tag of the trapping op.
- `exc_clear`  in  1  acknowledge trap.

## Operation
- **Operand register (OR):** one entry holding A, B, op, tag, trap_ov and `op_valid`. `alu_*` are driven from the OR.
- **Output buffer (OB):** in-order FIFO of {result, zero, carry, overflow, tag}. Depth is DEPTH (see Configuration).
- **Advance:** `adv = op_valid && (ob_count < DEPTH || (out_valid && out_ready))`. On `adv`, the OR entry is written to the OB tail; an empty OB still counts as a write.
- **Ready:** `in_ready = rst_n && state==RUN && (!op_valid || adv)`. Accept `in_valid && in_ready` into the OR.
- **Unsupported ALUop (011, 100, 101):**
  - The op is accepted.
  - `alu_ALUop` is driven as 000.
  - The OB entry is result 0, zero 1, carry 0, overflow 0.
- **FSM:**
  - RUN: normal operation.
  - TRAP: enter from RUN when `adv` and `trap_ov` and `alu_Overflow` and op ∈ {010, 110}.
    - The trapping entry is NOT written to the OB.
    - `exc_tag` latches its tag.
    - `exc_valid` = 1 while in TRAP.
  - In TRAP, `in_ready` = 0 and the OB continues draining.
  - TRAP → RUN on the cycle `exc_clear` = 1. `exc_clear` is ignored in RUN.
- **OB push and pop in the same cycle:** count unchanged; the FIFO stays in order.
- **Reset:**
  - All outputs go to 0: `out_valid`, `exc_valid`, `in_ready`, all data, and `alu_*`.
  - `op_valid` = 0, OB empty, state RUN.
  - Reset asserted mid-operation discards every in-flight entry and any pending trap.

## Timing
- Latency: a request accepted at edge N drives the ALU during cycle N+1. At edge N+1 it is written to the OB, so `out_valid` = 1 in cycle N+1 after that edge. Minimum latency is 2 edges from presentation to pop.
- Throughput: 1 op/cycle while `out_ready` = 1.
- Backpressure: when the OB is full and `out_ready` = 0, `adv` = 0 and the OR holds. `in_ready` = 0 only if the OR is also occupied.
- `out_*` are register outputs and hold stable while `out_valid && !out_ready`.
- `in_ready` is combinational from state and the OB/OR counts. It does not depend on `in_valid`.

## Configuration
- `ALU_EX_SKID_EN` defined: DEPTH = 2. Full-rate operation is sustained through one cycle of `out_ready` deassertion without dropping `in_ready`.
- `ALU_EX_SKID_EN` undefined: DEPTH = 1. With the OB full and `out_ready` = 0, a queued OR blocks input immediately.

## Test plan
- **Reset:** hold `rst_n` = 0 for 3 cycles with `in_valid` = 1 → `in_ready` = 0, `out_valid` = 0, `exc_valid` = 0. After release, `in_ready` = 1.
- **ADD:** ADD A=0x7FFFFFFF, B=1, `trap_ov` = 0 → 2 edges later `out_result` = 0x80000000, `out_overflow` = 1, `out_carry` = 0, tag preserved.
- **Overflow trap:**
  - SUB A=0x80000000, B=1, `trap_ov` = 1 → `exc_valid` = 1, `exc_tag` = the op's tag, no OB entry, `in_ready` = 0.
  - Pulse `exc_clear` → RUN, `in_ready` = 1 the next cycle.
- **Backpressure:** stream 4 ops (SLT 5,7 → 1; SLT 7,5 → 0; AND 0xF0F0,0xFF00 → 0xF000; OR 0,0 → 0, zero = 1) with `out_ready` low for 3 cycles mid-stream → all 4 results pop in order with none lost.
  - With `ALU_EX_SKID_EN`: `in_ready` stays high during the first stall cycle.
  - Without `ALU_EX_SKID_EN`: `in_ready` drops in that cycle.
- **Unsupported op:** op 100 with A=B=0xFFFFFFFF → `alu_ALUop` = 000, `out_result` = 0, `out_zero` = 1, `out_carry` = 0, `out_overflow` = 0.
- **Reset mid-stream:** assert `rst_n` = 0 with the OR and OB occupied and TRAP pending → on the next cycle every valid and `exc_valid` = 0; no stale result appears after release.
